// File: rtl/demux_1_a_4_pkg.sv
// Shared constants and the destination-select helper for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_CANALES = 4;
    localparam int SEL_W       = 2;

    localparam logic MODO_DIRIGIDO = 1'b0;
    localparam logic MODO_RR       = 1'b1;

    // Destination channel: the internal pointer in round-robin mode, otherwise the selector.
    function automatic logic [SEL_W-1:0] destino(input logic             modo,
                                                 input logic [SEL_W-1:0] sel,
                                                 input logic [SEL_W-1:0] ptr);
        return (modo == MODO_RR) ? ptr : sel;
    endfunction

endpackage

// File: rtl/demux_1_a_4_if.sv
// Stream bus of the 1-to-4 demultiplexer: one upstream input and four downstream channels.
interface demux_1_a_4_if #(parameter int n = 4);

    logic [n-1:0] i_Datos;
    logic         i_valid;
    logic         o_ready;
    logic [1:0]   i_sel;
    logic         i_modo;
    logic [1:0]   o_ptr;

    logic [n-1:0] o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3;
    logic         o_valid_0, o_valid_1, o_valid_2, o_valid_3;
    logic         i_ready_0, i_ready_1, i_ready_2, i_ready_3;

    // Environment side: drives the upstream word and the downstream ready lines.
    modport master (
        output i_Datos, i_valid, i_sel, i_modo,
        output i_ready_0, i_ready_1, i_ready_2, i_ready_3,
        input  o_ready, o_ptr,
        input  o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3,
        input  o_valid_0, o_valid_1, o_valid_2, o_valid_3
    );

    // Demultiplexer side.
    modport slave (
        input  i_Datos, i_valid, i_sel, i_modo,
        input  i_ready_0, i_ready_1, i_ready_2, i_ready_3,
        output o_ready, o_ptr,
        output o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3,
        output o_valid_0, o_valid_1, o_valid_2, o_valid_3
    );

endinterface

// File: rtl/demux_1_a_4_canal_salida.sv
// One-entry holding register for a single output channel of the demultiplexer.
module canal_salida #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [n-1:0] load_datos,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [n-1:0] o_Datos,
    output logic         o_acepta
);

    logic         valid_reg, valid_next;
    logic [n-1:0] datos_reg, datos_next;

    // A load in the same cycle as a drain keeps the channel full with the new word.
    always_comb begin
        valid_next = valid_reg;
        datos_next = datos_reg;
        if (load) begin
            valid_next = 1'b1;
            datos_next = load_datos;
        end else if (valid_reg && i_ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            datos_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            datos_reg <= datos_next;
        end
    end

    assign o_valid  = valid_reg;
    assign o_Datos  = datos_reg;
    assign o_acepta = !valid_reg || i_ready;

endmodule

// File: rtl/demux_1_a_4.sv
// Registered 1-to-4 stream demultiplexer with directed or round-robin routing.
module demux_1_a_4
    import demux_pkg::*;
#(
    parameter int n = 4
) (
    input logic          i_clk,
    input logic          i_rst,
    demux_1_a_4_if.slave bus
);

    logic [SEL_W-1:0]       ptr_reg, ptr_next;
    logic [SEL_W-1:0]       destino_sel;
    logic [NUM_CANALES-1:0] ready_vec;
    logic [NUM_CANALES-1:0] acepta_vec;
    logic [NUM_CANALES-1:0] valid_vec;
    logic [NUM_CANALES-1:0] load_vec;
    logic [n-1:0]           datos_arr [NUM_CANALES];
    logic                   acepta_entrada;

    assign ready_vec = {bus.i_ready_3, bus.i_ready_2, bus.i_ready_1, bus.i_ready_0};

    assign destino_sel    = destino(bus.i_modo, bus.i_sel, ptr_reg);
    assign bus.o_ready    = acepta_vec[destino_sel];
    assign acepta_entrada = bus.i_valid && bus.o_ready;

    generate
        for (genvar gi = 0; gi < NUM_CANALES; gi++) begin : g_canal
            assign load_vec[gi] = acepta_entrada && (destino_sel == SEL_W'(gi));

            canal_salida #(.n(n)) u_canal (
                .clk        (i_clk),
                .rst        (i_rst),
                .load       (load_vec[gi]),
                .load_datos (bus.i_Datos),
                .i_ready    (ready_vec[gi]),
                .o_valid    (valid_vec[gi]),
                .o_Datos    (datos_arr[gi]),
                .o_acepta   (acepta_vec[gi])
            );
        end
    endgenerate

    // The pointer only advances on words actually accepted in round-robin mode.
    always_comb begin
        ptr_next = ptr_reg;
        if (acepta_entrada && (bus.i_modo == MODO_RR))
            ptr_next = ptr_reg + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            ptr_reg <= '0;
        else
            ptr_reg <= ptr_next;
    end

    assign bus.o_ptr = ptr_reg;

    assign bus.o_Datos_0 = datos_arr[0];
    assign bus.o_Datos_1 = datos_arr[1];
    assign bus.o_Datos_2 = datos_arr[2];
    assign bus.o_Datos_3 = datos_arr[3];

    assign bus.o_valid_0 = valid_vec[0];
    assign bus.o_valid_1 = valid_vec[1];
    assign bus.o_valid_2 = valid_vec[2];
    assign bus.o_valid_3 = valid_vec[3];

endmodule
